// File: rtl/turbo_encoder_core_pkg.sv
// turbo_enc_pkg: shared FSM encoding, tail length and default block-length limits for turbo_encoder_core.
package turbo_enc_pkg;
  localparam int TAIL_LEN = 3;
  localparam int DEF_K_MIN = 40;
  localparam int DEF_K_MAX = 6144;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_TAIL1 = 2'd2;
  localparam logic [1:0] ST_TAIL2 = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA,
    TAIL1 = ST_TAIL1,
    TAIL2 = ST_TAIL2
  } enc_state_e;
endpackage

// File: rtl/turbo_encoder_core_if.sv
// turbo_encoder_core_if: input pair stream (in_valid/in_ready/ck1/ck2) and output beat stream
// (out_valid/out_ready/xk1/zk1/xk2/zk2/out_tail/out_last); slave = core side, master = feeder/sink side.
interface turbo_encoder_core_if;
  logic in_valid, in_ready, ck1, ck2;
  logic out_valid, out_ready, xk1, zk1, xk2, zk2, out_tail, out_last;
  modport master (
    output in_valid, ck1, ck2, out_ready,
    input  in_ready, out_valid, xk1, zk1, xk2, zk2, out_tail, out_last
  );
  modport slave (
    input  in_valid, ck1, ck2, out_ready,
    output in_ready, out_valid, xk1, zk1, xk2, zk2, out_tail, out_last
  );
endinterface

// File: rtl/turbo_encoder_core_rsc.sv
// rsc_encoder: 8-state RSC constituent encoder; clk, reset (sync active-low), clr, en, tail (step select),
// c (data bit) in; x, z out (s_out state when TURBO_ENC_STATS_EN is defined).
module rsc_encoder (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic tail,
  input  logic c,
  output logic x,
  output logic z
`ifdef TURBO_ENC_STATS_EN
  ,
  output logic [2:0] s_out
`endif
);
  logic [2:0] s;
  logic a;
  always_comb begin
    a = tail ? 1'b0 : c ^ s[1] ^ s[0];
    z = a ^ s[2] ^ s[0];
    x = tail ? s[1] ^ s[0] : c;
  end
  always_ff @(posedge clk)
    if (!reset || clr) s <= '0;
    else if (en) s <= {a, s[2:1]};
`ifdef TURBO_ENC_STATS_EN
  assign s_out = s;
`endif
endmodule

// File: rtl/turbo_encoder_core.sv
// turbo_encoder_core: LTE rate-1/3 turbo encoder with programmable block length and trellis termination.
// Ports: clk, reset (sync active-low), start/k_size (block request), cfg_err (illegal k_size pulse),
// busy, io (turbo_encoder_core_if.slave: input pairs and output beats).
// Optional TURBO_ENC_STATS_EN adds blk_cnt and rsc_nonzero_err.
module turbo_encoder_core
  import turbo_enc_pkg::*;
#(
  parameter int KW = 13,
  parameter int K_MIN = DEF_K_MIN,
  parameter int K_MAX = DEF_K_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_size,
  output logic          cfg_err,
  output logic          busy,
  turbo_encoder_core_if.slave io
`ifdef TURBO_ENC_STATS_EN
  ,
  output logic [15:0]   blk_cnt,
  output logic          rsc_nonzero_err
`endif
);
  enc_state_e st;
  logic [KW-1:0] k_reg, cnt;
  logic [1:0] tcnt;
  logic x1, z1, x2, z2, slot_free, acc, t1_go, t2_go, ld, done, k_ok, go;
  assign slot_free = !io.out_valid || io.out_ready;
  assign io.in_ready = (st == DATA) && slot_free;
  assign acc = io.in_valid && io.in_ready;
  assign t1_go = (st == TAIL1) && slot_free;
  // tcnt reaching TAIL_LEN in TAIL2 means all tail beats are loaded and we only wait for the drain
  assign t2_go = (st == TAIL2) && slot_free && (tcnt != 2'(TAIL_LEN));
  assign ld = acc || t1_go || t2_go;
  assign done = (st == TAIL2) && io.out_valid && io.out_ready && io.out_last;
  assign k_ok = (k_size >= KW'(K_MIN)) && (k_size <= KW'(K_MAX));
  assign go = (st == IDLE) && start && k_ok;
  assign busy = st != IDLE;
`ifdef TURBO_ENC_STATS_EN
  logic [2:0] s1, s2;
`endif
  rsc_encoder u_rsc1 (
    .clk(clk), .reset(reset), .clr(go), .en(acc || t1_go), .tail(st == TAIL1),
    .c(io.ck1), .x(x1), .z(z1)
`ifdef TURBO_ENC_STATS_EN
    , .s_out(s1)
`endif
  );
  rsc_encoder u_rsc2 (
    .clk(clk), .reset(reset), .clr(go), .en(acc || t2_go), .tail(st == TAIL2),
    .c(io.ck2), .x(x2), .z(z2)
`ifdef TURBO_ENC_STATS_EN
    , .s_out(s2)
`endif
  );
  always_ff @(posedge clk)
    if (!reset) begin
      st <= IDLE;
      k_reg <= '0;
      cnt <= '0;
      tcnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (st == IDLE) && start && !k_ok;
      case (st)
        IDLE: if (go) begin
          st <= DATA;
          k_reg <= k_size;
          cnt <= '0;
        end
        DATA: if (acc) begin
          cnt <= cnt + 1'b1;
          if (cnt == k_reg - 1'b1) begin
            st <= TAIL1;
            tcnt <= '0;
          end
        end
        TAIL1: if (t1_go) begin
          tcnt <= (tcnt == 2'(TAIL_LEN - 1)) ? 2'd0 : tcnt + 2'd1;
          if (tcnt == 2'(TAIL_LEN - 1)) st <= TAIL2;
        end
        default: begin
          if (t2_go) tcnt <= tcnt + 2'd1;
          if (done) st <= IDLE;
        end
      endcase
    end
  always_ff @(posedge clk)
    if (!reset) begin
      io.out_valid <= 1'b0;
      {io.xk1, io.zk1, io.xk2, io.zk2, io.out_tail, io.out_last} <= '0;
    end else if (slot_free) begin
      io.out_valid <= ld;
      if (ld) begin
        io.xk1 <= (st == TAIL2) ? 1'b0 : x1;
        io.zk1 <= (st == TAIL2) ? 1'b0 : z1;
        io.xk2 <= (st == TAIL2) ? x2 : 1'b0;
        io.zk2 <= (st == TAIL1) ? 1'b0 : z2;
        io.out_tail <= st != DATA;
        io.out_last <= t2_go && (tcnt == 2'(TAIL_LEN - 1));
      end
    end
`ifdef TURBO_ENC_STATS_EN
  always_ff @(posedge clk)
    if (!reset) begin
      blk_cnt <= '0;
      rsc_nonzero_err <= 1'b0;
    end else if (done) begin
      blk_cnt <= blk_cnt + 16'd1;
      if (s1 != 3'd0 || s2 != 3'd0) rsc_nonzero_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_turbo_encoder_core.sv
// tb_turbo_encoder_core: self-checking bench with a history-array turbo encoder model and a config vector table.
module tb_turbo_encoder_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [12:0] k_size = '0;
  logic cfg_err, busy;
  turbo_encoder_core_if io ();
`ifdef TURBO_ENC_STATS_EN
  logic [15:0] blk_cnt;
  logic rsc_nonzero_err;
`endif
  always #5 clk = ~clk;
  turbo_encoder_core dut (
    .clk(clk), .reset(reset), .start(start), .k_size(k_size),
    .cfg_err(cfg_err), .busy(busy), .io(io)
`ifdef TURBO_ENC_STATS_EN
    , .blk_cnt(blk_cnt), .rsc_nonzero_err(rsc_nonzero_err)
`endif
  );
  int checks = 0;
  int errors = 0;
  logic [5:0] got[$];
  typedef struct {
    int   k;
    logic err;
  } cfg_vec_t;
  cfg_vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] all_outs();
    return {cfg_err, busy, io.in_ready, io.out_valid, io.xk1, io.zk1, io.xk2, io.zk2,
            io.out_tail, io.out_last};
  endfunction

  // mode: 0 all zero, 1 impulse on ck1 bit 0, 2 random
  task automatic run_block(input int k, input int mode, input bit rnd_io, input bit stall,
                           input bit mid_start);
    bit c1[], c2[];
    bit a1[$] = '{1'b0, 1'b0, 1'b0};
    bit a2[$] = '{1'b0, 1'b0, 1'b0};
    logic [5:0] exp[$];
    logic [5:0] cur, hv;
    int inp = 0, cyc = 0, stall_left = 0, m;
    bit hold = 0, s1d = 0, s2d = 0;
    c1 = new[k];
    c2 = new[k];
    for (int n = 0; n < k; n++) begin
      c1[n] = (mode == 2) ? ($urandom % 2 == 1) : (mode == 1 && n == 0);
      c2[n] = (mode == 2) ? ($urandom % 2 == 1) : 1'b0;
    end
    // feedback history: a[n] = c ^ a[n-2] ^ a[n-3], parity z = a[n] ^ a[n-1] ^ a[n-3]
    for (int n = 0; n < k; n++) begin
      bit b1, b2;
      m = a1.size();
      b1 = c1[n] ^ a1[m-2] ^ a1[m-3];
      b2 = c2[n] ^ a2[m-2] ^ a2[m-3];
      exp.push_back({c1[n], b1 ^ a1[m-1] ^ a1[m-3], 1'b0, b2 ^ a2[m-1] ^ a2[m-3], 2'b00});
      a1.push_back(b1);
      a2.push_back(b2);
    end
    // termination: input chosen to force the feedback value to 0
    for (int j = 0; j < 3; j++) begin
      m = a1.size();
      exp.push_back({a1[m-2] ^ a1[m-3], a1[m-1] ^ a1[m-3], 2'b00, 2'b10});
      a1.push_back(1'b0);
    end
    for (int j = 0; j < 3; j++) begin
      m = a2.size();
      exp.push_back({2'b00, a2[m-2] ^ a2[m-3], a2[m-1] ^ a2[m-3], 1'b1, j == 2});
      a2.push_back(1'b0);
    end
    @(negedge clk);
    start = 1'b1;
    k_size = 13'(k);
    @(negedge clk);
    start = 1'b0;
    check("busy_on", busy, 1);
    got.delete();
    while (got.size() < k + 6 && cyc < 8 * (k + 6) + 200) begin
      if (stall && got.size() == 50 && !s1d) begin stall_left = 5; s1d = 1; end
      if (stall && got.size() == k + 1 && !s2d) begin stall_left = 2; s2d = 1; end
      io.out_ready = (stall_left > 0) ? 1'b0 : (rnd_io ? ($urandom % 4 != 0) : 1'b1);
      if (stall_left > 0) stall_left--;
      io.in_valid = (inp < k) ? (rnd_io ? ($urandom % 4 != 0) : 1'b1) : ($urandom % 2 == 1);
      io.ck1 = (inp < k) ? c1[inp] : ($urandom % 2 == 1);
      io.ck2 = (inp < k) ? c2[inp] : ($urandom % 2 == 1);
      start = mid_start && got.size() == 5;
      k_size = 13'd39;
      #1;
      cur = {io.xk1, io.zk1, io.xk2, io.zk2, io.out_tail, io.out_last};
      if (hold) check("hold", {io.out_valid, cur}, {1'b1, hv});
      hold = io.out_valid && !io.out_ready;
      hv = cur;
      if (hold) check("stall_in_ready", io.in_ready, 0);
      if (inp >= k) check("in_ready_late", io.in_ready, 0);
      check("cfg_err_quiet", cfg_err, 0);
      if (io.in_valid && io.in_ready) inp++;
      if (io.out_valid && io.out_ready) begin
        check($sformatf("beat%0d", got.size()), cur, exp[got.size()]);
        got.push_back(cur);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    check("beat_count", got.size(), k + 6);
    check("busy_off", busy, 0);
  endtask

  initial begin
    tbl = '{'{39, 1'b1}, '{6145, 1'b1}, '{0, 1'b1}, '{8191, 1'b1},
            '{40, 1'b0}, '{6144, 1'b0}, '{1000, 1'b0}};
    {io.in_valid, io.ck1, io.ck2, io.out_ready} = '0;
    repeat (2) @(negedge clk);
    check("reset_state", all_outs(), 0);
    reset = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      start = 1'b1;
      k_size = 13'(tbl[i].k);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("cfg_err_k%0d", tbl[i].k), cfg_err, tbl[i].err);
      check($sformatf("cfg_busy_k%0d", tbl[i].k), busy, !tbl[i].err);
      @(negedge clk);
      check("cfg_err_pulse", cfg_err, 0);
      if (!tbl[i].err) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("cfg_abort_busy", busy, 0);
      end
    end
    run_block(40, 0, 0, 0, 0);
    for (int i = 0; i < 46; i++) begin
      if (i < 40) check($sformatf("zero_data%0d", i), got[i][5:2], 0);
      check($sformatf("zero_tail%0d", i), got[i][1], i >= 40);
      check($sformatf("zero_last%0d", i), got[i][0], i == 45);
    end
    run_block(40, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("imp_xk1_%0d", i), got[i][5], i == 0);
      check($sformatf("imp_zk1_%0d", i), got[i][4], 1);
    end
    for (int i = 0; i < 40; i++) check($sformatf("imp_zk2_%0d", i), got[i][2], 0);
    run_block(104, 2, 1, 1, 1);
    @(negedge clk);
    start = 1'b1;
    k_size = 13'd40;
    @(negedge clk);
    start = 1'b0;
    io.in_valid = 1'b1;
    io.out_ready = 1'b1;
    begin
      int n = 0, cyc = 0;
      while (n < 20 && cyc < 200) begin
        io.ck1 = ($urandom % 2 == 1);
        io.ck2 = ($urandom % 2 == 1);
        #1;
        if (io.out_valid && io.out_ready) n++;
        @(negedge clk);
        cyc++;
      end
      check("reset_beats_reached", n, 20);
    end
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_outs", all_outs(), 0);
    reset = 1'b1;
    io.in_valid = 1'b0;
    run_block(40, 2, 0, 0, 0);
    run_block(6144, 2, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/turbo_encoder_core.md
Name: turbo_encoder_core

Overview:
- Parametrised LTE-style rate-1/3 turbo encoder core.
- Two 8-state RSC constituent encoders are fed natural bits (ck1) and interleaved bits (ck2) in lockstep.
- A run-time block length is programmed per block. Each block ends with trellis termination: 6 tail beats, 12 tail bits.
- Input and output both use valid/ready handshakes with full backpressure. The core sits between the interleaver output and the rate matcher, replacing the fixed single-length encoder wrapper.

Parameters:
KW, 13, width of block-length input and internal bit counter
K_MIN, 40, smallest legal block length
K_MAX, 6144, largest legal block length (must be < 2**KW)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a block; sampled only in IDLE
k_size  input  KW  block length, sampled with start
cfg_err  output  1  one-cycle pulse: start rejected because k_size is outside [K_MIN,K_MAX]
busy  output  1  high from accepted start until last output beat is accepted
in_valid  input  1  ck1/ck2 pair valid
in_ready  output  1  core accepts pair this cycle
ck1  input  1  natural-order systematic bit
ck2  input  1  interleaved bit
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
xk1  output  1  systematic / encoder-1 tail x
zk1  output  1  encoder-1 parity
xk2  output  1  encoder-2 tail x (0 during data beats)
zk2  output  1  encoder-2 parity
out_tail  output  1  beat is a tail beat
out_last  output  1  final beat of block (6th tail beat)

Behaviour:
- Reset (reset==0 at clk edge): FSM=IDLE, both RSC states=000, counter=0. All outputs 0 (busy, in_ready, out_valid, cfg_err, data bits). Reset mid-block aborts the block; no partial tail is emitted.
- RSC state s=(s1,s2,s3):
  - Data step: a=c^s2^s3; z=a^s1^s3; next s=(a,s1,s2); x=c.
  - Tail step: x=s2^s3; a=0; z=s1^s3; next s=(0,s1,s2).
- Output register (one stage):
  - Beat loads when (!out_valid || out_ready).
  - in_ready = (state==DATA) && (!out_valid || out_ready).
  - Latency is 1 cycle from input accept to out_valid.
- FSM:
  - IDLE: start with legal k_size latches K, clears RSC states and counter, goes to DATA. Illegal k_size pulses cfg_err and stays in IDLE.
  - DATA: each accepted pair encodes both RSCs and emits beat {xk1=ck1, zk1=z1, xk2=0, zk2=z2}, with out_tail=0 and counter+1. The accept with counter==K-1 moves to TAIL1.
  - TAIL1 (3 beats): encoder 1 tail step, emitting {xk1=x1, zk1=z1, xk2=0, zk2=0}, out_tail=1. Encoder 2 holds.
  - TAIL2 (3 beats): encoder 2 tail step, emitting {xk1=0, zk1=0, xk2=x2, zk2=z2}, out_tail=1. The 3rd beat has out_last=1.
  - Tail beats load only when the output slot is free.
  - After the out_last beat is accepted: busy=0, return to IDLE.
- A block is exactly K+6 beats. Both RSC states equal 000 after their tail.
- start is ignored (no cfg_err) when not in IDLE. start in the same cycle the last beat is accepted is ignored.
- in_valid outside DATA: no effect; in_ready stays 0.
- While out_valid && !out_ready, all output bits are held stable.

Optional Feature:
- Macro TURBO_ENC_STATS_EN.
- Defined: adds output blk_cnt[15:0], incremented (wrapping) on each out_last acceptance. Also adds output rsc_nonzero_err, a sticky flag set if either RSC state is not 000 after its tail. Both are cleared by reset.
- Undefined: neither port exists and no logic is added.

Decomposition:
- Package turbo_enc_pkg holds:
  - FSM state enum (IDLE, DATA, TAIL1, TAIL2)
  - tail length constant (3 per encoder)
  - default K_MIN/K_MAX
- One natural sub-module: rsc_encoder. It has a 3-bit state register, a data/tail step select, an enable and a clear, and outputs x and z. Instantiated twice.

Test Plan:
- K=40, all ck1=ck2=0, out_ready=1 -> 46 beats, all data bits 0. out_tail high on beats 40-45, out_last only on beat 45, busy low after it.
- K=40, ck1=1 on bit 0 only, ck2=0 -> beats 0-3: xk1=1,0,0,0 and zk1=1,1,1,1. zk2=0 throughout data. Tail matches the golden model and ends in state 000.
- K=6144 random ck1/ck2 vs C golden model -> every one of 6150 beats matches.
- K=104 random input; out_ready held low 5 cycles at beat 50 and 2 cycles during TAIL1 -> outputs stable while stalled, in_ready=0, no bit lost or duplicated.
- start with k_size=39, then 6145 -> cfg_err pulses each time, busy stays 0. start during DATA -> ignored.
- reset low at beat 20 of K=40 -> next cycle all outputs 0, IDLE. A new K=40 block then encodes identically to a fresh run.
